// File: rtl/tmr_vote_ctrl.sv
// tmr_vote_ctrl: sequencing controller for a three-channel 2-bit majority voter.
// Votes one triplicated sample per in_valid strobe with one cycle of latency.
// Tracks consecutive dissents per channel, retires a persistently dissenting
// channel (TRIPLE -> DUAL) and latches FAIL when the two survivors disagree.
module tmr_vote_ctrl #(
   parameter int unsigned THRESH = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic [1:0] c,
   input  logic       clear,
   output logic       out_valid,
   output logic [1:0] major,
   output logic [1:0] flags,
   output logic [2:0] fault_mask,
   output logic [1:0] mode,
   output logic       err
);

   localparam int unsigned     CW       = $clog2(THRESH + 1);
   localparam logic [CW-1:0]   THRESH_C = CW'(THRESH);

   typedef enum logic [1:0] {
      MODE_TRIPLE = 2'b00,
      MODE_DUAL   = 2'b01,
      MODE_FAIL   = 2'b10
   } mode_e;

   localparam logic [1:0] FLAGS_ALL  = 2'b11;
   localparam logic [1:0] FLAGS_TWO  = 2'b10;
   localparam logic [1:0] FLAGS_NONE = 2'b00;

   mode_e         mode_q, mode_d;
   logic [2:0]    mask_q, mask_d;
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];
   logic          out_valid_q, out_valid_d;
   logic [1:0]    major_q, major_d;
   logic [1:0]    flags_q, flags_d;
   logic          err_q, err_d;

   // Triple-rule vote: value, agreement flags and the one-hot dissenting channel.
   logic [1:0] tri_major;
   logic [1:0] tri_flags;
   logic [2:0] tri_dissent;

   // Dual-rule vote: the two channels still in service.
   logic [1:0] dual_x;
   logic [1:0] dual_y;
   logic       dual_ok;

   // Combinational triple-redundant vote on the raw inputs.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      tri_major   = 2'b00;
      tri_flags   = FLAGS_NONE;
      tri_dissent = 3'b000;
      if ((a == b) && (b == c)) begin
         tri_major = a;
         tri_flags = FLAGS_ALL;
      end else if (a == b) begin
         tri_major   = a;
         tri_flags   = FLAGS_TWO;
         tri_dissent = 3'b100;
      end else if (a == c) begin
         tri_major   = a;
         tri_flags   = FLAGS_TWO;
         tri_dissent = 3'b010;
      end else if (b == c) begin
         tri_major   = b;
         tri_flags   = FLAGS_TWO;
         tri_dissent = 3'b001;
      end
   end

   // Select the two healthy channels once one has been retired.
   always_comb begin
      dual_x = a;
      dual_y = b;
      unique case (mask_q)
         3'b001:  begin dual_x = b; dual_y = c; end
         3'b010:  begin dual_x = a; dual_y = c; end
         default: begin dual_x = a; dual_y = b; end
      endcase
      dual_ok = (dual_x == dual_y);
   end

   // Next-state logic: mode transitions, dissent counters and registered vote.
   always_comb begin
      mode_d      = mode_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      major_d     = major_q;
      flags_d     = flags_q;
      // Outside a sample, err only persists once FAIL has latched.
      err_d       = (mode_q == MODE_FAIL);

      if (clear) begin
         // Recovery wins over a coincident sample, which is dropped.
         mode_d = MODE_TRIPLE;
         mask_d = 3'b000;
         err_d  = 1'b0;
         for (int i = 0; i < 3; i++) cnt_d[i] = '0;
      end else if (in_valid) begin
         out_valid_d = 1'b1;
         unique case (mode_q)
            MODE_TRIPLE: begin
               major_d = tri_major;
               flags_d = tri_flags;
               if (tri_flags == FLAGS_NONE) begin
                  err_d = 1'b1;
               end else begin
                  // Agreement clears a channel's run; only the lone dissenter counts up.
                  for (int i = 0; i < 3; i++) begin
                     if (tri_dissent[i]) begin
                        if (cnt_q[i] != THRESH_C) cnt_d[i] = cnt_q[i] + CW'(1);
                        if (cnt_d[i] == THRESH_C) begin
                           mask_d[i] = 1'b1;
                           mode_d    = MODE_DUAL;
                        end
                     end else begin
                        cnt_d[i] = '0;
                     end
                  end
               end
            end
            MODE_DUAL: begin
               if (dual_ok) begin
                  major_d = dual_x;
                  flags_d = FLAGS_TWO;
               end else begin
                  major_d = 2'b00;
                  flags_d = FLAGS_NONE;
                  mode_d  = MODE_FAIL;
                  err_d   = 1'b1;
               end
            end
            default: begin
               major_d = 2'b00;
               flags_d = FLAGS_NONE;
               mode_d  = MODE_FAIL;
               err_d   = 1'b1;
            end
         endcase
      end
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q      <= MODE_TRIPLE;
         mask_q      <= 3'b000;
         out_valid_q <= 1'b0;
         major_q     <= 2'b00;
         flags_q     <= FLAGS_NONE;
         err_q       <= 1'b0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         mode_q      <= mode_d;
         mask_q      <= mask_d;
         out_valid_q <= out_valid_d;
         major_q     <= major_d;
         flags_q     <= flags_d;
         err_q       <= err_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // Output drive straight from the registers.
   always_comb begin
      out_valid  = out_valid_q;
      major      = major_q;
      flags      = flags_q;
      fault_mask = mask_q;
      mode       = mode_q;
      err        = err_q;
   end

endmodule

// File: doc/tmr_vote_ctrl.md
# tmr_vote_ctrl

Sequencing controller for the three-channel 2-bit majority voter. It accepts one triplicated sample per `in_valid` strobe and produces a registered vote. It tracks per-channel disagreement history and retires a channel once it has dissented THRESH times in a row. After a retirement it degrades from triple to dual voting, then to a latched failure state. It sits between the redundant sources and downstream logic, which consumes `major`/`flags` under `out_valid`.

## Interface
- THRESH, 3, consecutive dissents that retire a channel; legal range 1..15; counters are $clog2(THRESH+1) bits wide.

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample a/b/c this cycle
- a, b, c  in  2 each  redundant channel values (channel 0 = a, 1 = b, 2 = c)
- clear  in  1  synchronous recovery: restores TRIPLE, unmasks all channels
- out_valid  out  1  one-cycle strobe, result of an accepted sample
- major  out  2  voted value
- flags  out  2  11 all healthy agree, 10 two agree, 00 no majority
- fault_mask  out  3  bit i = channel i retired
- mode  out  2  00 TRIPLE, 01 DUAL, 10 FAIL
- err  out  1  no-majority indication

## Operation
- Reset values: out_valid 0, major 00, flags 00, fault_mask 000, mode 00, err 0, all counters 0.
- clear has priority over in_valid. In a clear cycle, counters go to 0, mask to 000, mode to TRIPLE and err to 0. A sample presented in the same cycle is discarded: no out_valid, major/flags hold.
- TRIPLE, on in_valid:
  - a==b==c: major=a, flags=11.
  - Exactly two equal: major=pair value, flags=10.
  - All differ: major=00, flags=00, err=1 for one cycle.
- TRIPLE, counter update:
  - flags 10: the dissenting channel's counter increments, saturating at THRESH; the two agreeing channels' counters clear.
  - flags 11: all counters clear.
  - flags 00: counters unchanged.
- TRIPLE, retirement: when a counter reaches THRESH, that channel's fault_mask bit sets and mode goes to DUAL. At most one channel can retire per sample.
- DUAL: the masked channel is ignored and its counter frozen.
  - Two healthy channels equal: major=value, flags=10.
  - Unequal: major=00, flags=00, mode goes to FAIL, err=1 and holds.
- FAIL: every in_valid still yields out_valid with major=00, flags=00. err stays 1 and fault_mask holds. Exit only via clear or rst.
- No path from DUAL back to TRIPLE other than clear/rst. mode 11 is unreachable.

## Timing
- Latency 1 cycle: out_valid, major, flags and err update at the edge that samples in_valid. out_valid is high for exactly that following cycle.
- major/flags hold their last value between samples. In TRIPLE, err is 0 in cycles without an out_valid pulse.
- Back-to-back in_valid every cycle is supported with no bubbles.
- mode, fault_mask and counters update at the same edge as the output they affect.
- The sample that causes a retirement is voted under TRIPLE rules (flags 10). The first DUAL-rule vote is the next sample.
- The sample that causes FAIL is reported as major 00, flags 00 with err=1 in the same output cycle.
- rst asserted mid-stream forces reset values immediately, independent of clk. The first sample is accepted at the first rising edge after deassertion.

## Test plan
- Reset, then in_valid with a=b=c=2 -> next cycle: out_valid=1, major=2, flags=11, mode=00, err=0.
- THRESH=3, three consecutive samples a=1, b=c=3 -> each cycle: major=3, flags=10. After the third: fault_mask=001, mode=01.
  - Variant: pattern bad, bad, good, bad, bad -> no retirement.
- DUAL with a retired:
  - a=0, b=c=2 -> major=2, flags=10.
  - Then a=2, b=1, c=2 -> major=0, flags=00, mode=10, err=1.
- FAIL, then a=b=c=3 -> out_valid=1, major=0, flags=00, err=1.
  - Then clear -> mode=00, fault_mask=000, err=0.
  - Then a=b=c=3 -> major=3, flags=11.
- TRIPLE with a=0, b=1, c=2 -> major=0, flags=00, err high exactly one cycle. Counters unchanged, mode=00.
- clear and in_valid in the same cycle -> no out_valid next cycle.
  - rst pulse between clock edges during a stream -> all outputs at reset values before the next edge.
